// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: holds the state and round-key registers and walks ARK/KE/SB/SR/MC through En/Ry handshakes.
// A step takes at least 2 cycles (En registered, result captured on En&Ry); a step whose Ry is missing for TO_CYC cycles aborts into ERR.
`timescale 1ns/1ps
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int TO_CYC = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Start,
  input  logic         Abort,
  input  logic [127:0] Data_in,
  input  logic [127:0] Key_in,
  output logic [127:0] Data_out,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic [3:0]   Round_num,
  output logic [127:0] Blk_in,
  output logic [127:0] Rk_cur,
  output logic         En_ARK,
  input  logic         Ry_ARK,
  output logic         En_SB,
  input  logic         Ry_SB,
  output logic         En_SR,
  input  logic         Ry_SR,
  output logic         En_MC,
  input  logic         Ry_MC,
  output logic         En_KE,
  input  logic         Ry_KE,
  input  logic [127:0] Out_ARK,
  input  logic [127:0] Out_SB,
  input  logic [127:0] Out_SR,
  input  logic [127:0] Out_MC,
  input  logic [127:0] Out_KE
);

  localparam int CW = $clog2(TO_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_ARK0, S_KE, S_SB, S_SR, S_MC, S_ARK, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     round_q, round_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     en_q, en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [4:0]     ry_vec;
  logic           step_ry;
  logic [127:0]   step_out;
  state_t         nxt;
  logic [3:0]     nxt_round;

  // Enable vector bit order: ARK, SB, SR, MC, KE (bit 0 .. bit 4).
  function automatic logic [4:0] en_for(input state_t s);
    case (s)
      S_ARK0, S_ARK: en_for = 5'b00001;
      S_SB:          en_for = 5'b00010;
      S_SR:          en_for = 5'b00100;
      S_MC:          en_for = 5'b01000;
      S_KE:          en_for = 5'b10000;
      default:       en_for = 5'b00000;
    endcase
  endfunction

  assign ry_vec  = {Ry_KE, Ry_MC, Ry_SR, Ry_SB, Ry_ARK};
  assign step_ry = |(en_q & ry_vec);

  always_comb begin
    nxt       = state_q;
    nxt_round = round_q;
    step_out  = Out_ARK;
    case (state_q)
      S_ARK0: begin
        nxt       = S_KE;
        nxt_round = 4'd1;
      end
      S_KE: nxt = S_SB;
      S_SB: begin
        nxt      = S_SR;
        step_out = Out_SB;
      end
      S_SR: begin
        // The final round has no MixColumns.
        nxt      = (round_q == 4'(NR)) ? S_ARK : S_MC;
        step_out = Out_SR;
      end
      S_MC: begin
        nxt      = S_ARK;
        step_out = Out_MC;
      end
      S_ARK: begin
        if (round_q == 4'(NR)) begin
          nxt = S_DONE;
        end else begin
          nxt       = S_KE;
          nxt_round = round_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_ARK0;
          st_d    = Data_in;
          rk_d    = Key_in;
          round_d = 4'd0;
          cnt_d   = '0;
          en_d    = en_for(S_ARK0);
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Abort outranks a capture landing on the same edge.
        if (Abort) begin
          state_d = S_IDLE;
          en_d    = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (step_ry) begin
          if (state_q == S_KE) rk_d = Out_KE;
          else                 st_d = step_out;
          state_d = nxt;
          round_d = nxt_round;
          en_d    = en_for(nxt);
          cnt_d   = '0;
          if (nxt == S_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else if (cnt_q == CW'(TO_CYC - 1)) begin
          state_d = S_ERR;
          en_d    = '0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Data_out  = st_q;
  assign Blk_in    = st_q;
  assign Rk_cur    = rk_q;
  assign Round_num = round_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign En_ARK    = en_q[0];
  assign En_SB     = en_q[1];
  assign En_SR     = en_q[2];
  assign En_MC     = en_q[3];
  assign En_KE     = en_q[4];

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round blocks with adjustable Ry latency, a ciphertext/latency
// scoreboard popped on Done, and a step-order scoreboard popped on every En&Ry capture.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  localparam int NR     = 10;
  localparam int TO_CYC = 16;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         Start = 1'b0;
  logic         Abort = 1'b0;
  logic [127:0] Data_in = '0;
  logic [127:0] Key_in = '0;
  logic [127:0] Data_out, Blk_in, Rk_cur;
  logic         Busy, Done, Err;
  logic [3:0]   Round_num;
  logic         En_ARK, En_SB, En_SR, En_MC, En_KE;
  logic         Ry_ARK, Ry_SB, Ry_SR, Ry_MC, Ry_KE;
  logic [127:0] Out_ARK, Out_SB, Out_SR, Out_MC, Out_KE;

  aes_round_ctrl #(.NR(NR), .TO_CYC(TO_CYC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Data_in(Data_in), .Key_in(Key_in), .Data_out(Data_out),
    .Busy(Busy), .Done(Done), .Err(Err), .Round_num(Round_num),
    .Blk_in(Blk_in), .Rk_cur(Rk_cur),
    .En_ARK(En_ARK), .Ry_ARK(Ry_ARK), .En_SB(En_SB), .Ry_SB(Ry_SB),
    .En_SR(En_SR), .Ry_SR(Ry_SR), .En_MC(En_MC), .Ry_MC(Ry_MC),
    .En_KE(En_KE), .Ry_KE(Ry_KE),
    .Out_ARK(Out_ARK), .Out_SB(Out_SB), .Out_SR(Out_SR), .Out_MC(Out_MC), .Out_KE(Out_KE)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- AES reference functions ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    for (int i = 0; i < 254; i++) b = gmul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] f_sb(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sbox[x[127-8*i -: 8]];
    return y;
  endfunction

  function automatic logic [127:0] f_sr(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] f_mc(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-8*(4*c)   -: 8];
      a1 = x[127-8*(4*c+1) -: 8];
      a2 = x[127-8*(4*c+2) -: 8];
      a3 = x[127-8*(4*c+3) -: 8];
      y[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      y[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      y[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      y[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return y;
  endfunction

  function automatic logic [127:0] f_ke(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w3, t, w0n, w1n, w2n, w3n;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < int'(r); i++) rc = xt(rc);
    w3 = k[31:0];
    t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
    w0n = k[127:96] ^ t;
    w1n = k[95:64] ^ w0n;
    w2n = k[63:32] ^ w1n;
    w3n = k[31:0] ^ w2n;
    return {w0n, w1n, w2n, w3n};
  endfunction

  assign Out_ARK = Blk_in ^ Rk_cur;
  assign Out_SB  = f_sb(Blk_in);
  assign Out_SR  = f_sr(Blk_in);
  assign Out_MC  = f_mc(Blk_in);
  assign Out_KE  = f_ke(Rk_cur, Round_num);

  // ---------------- Block ready models ----------------
  // Bit order ARK, SB, SR, MC, KE; Ry pulses lat+1 cycles after En rises.
  logic [4:0] en_v, ry_v;
  int         wcnt [5];
  int         lat_sb = 0;
  logic       hang_mc = 1'b0;

  assign en_v = {En_KE, En_MC, En_SR, En_SB, En_ARK};
  assign {Ry_KE, Ry_MC, Ry_SR, Ry_SB, Ry_ARK} = ry_v;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ry_v <= '0;
      for (int i = 0; i < 5; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!en_v[i] || ry_v[i]) begin
          ry_v[i] <= 1'b0;
          wcnt[i] <= 0;
        end else if (i == 3 && hang_mc && Round_num == 4'd3) begin
          ry_v[i] <= 1'b0;
        end else if (wcnt[i] >= ((i == 1) ? lat_sb : 0)) begin
          ry_v[i] <= 1'b1;
        end else begin
          wcnt[i] <= wcnt[i] + 1;
        end
      end
    end
  end

  // ---------------- Scoreboards ----------------
  typedef struct packed {
    logic [127:0] ct;
    logic [31:0]  lat;
  } exp_t;

  exp_t       done_q [$];
  logic [2:0] step_q [$];
  int         edge_cnt = 0;
  int         start_edge = 0;
  exp_t       e_pop;
  logic [4:0] exp_en;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && Done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", Done, 0);
      end else begin
        e_pop = done_q.pop_front();
        chk("ciphertext", Data_out, e_pop.ct);
        chk("done_edge", edge_cnt - start_edge, e_pop.lat);
        chk("busy_at_done", Busy, 0);
        chk("round_at_done", Round_num, NR);
      end
    end
  end

  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      chk("en_onehot", $countones(en_v) <= 1, 1);
      chk("mc_in_last_round", En_MC && Round_num == 4'(NR), 0);
      if (|(en_v & ry_v)) begin
        if (step_q.size() == 0) begin
          chk("step_extra", en_v, 0);
        end else begin
          exp_en = 5'd1 << step_q.pop_front();
          chk("step_order", en_v, exp_en);
        end
      end
    end
  end

  task automatic do_start(input bit exp_done, input int exp_lat);
    exp_t e;
    @(negedge Clk);
    Data_in = PT;
    Key_in  = KEY;
    Start   = 1'b1;
    step_q.delete();
    step_q.push_back(3'd0);
    for (int r = 1; r <= NR; r++) begin
      step_q.push_back(3'd4);
      step_q.push_back(3'd1);
      step_q.push_back(3'd2);
      if (r < NR) step_q.push_back(3'd3);
      step_q.push_back(3'd0);
    end
    if (exp_done) begin
      e.ct  = CT;
      e.lat = exp_lat;
      done_q.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int busy_low = 0;
    while (Done !== 1'b1 && n < budget) begin
      if (Busy !== 1'b1) busy_low++;
      @(negedge Clk);
      n++;
    end
    chk("done_seen", Done, 1);
    chk("busy_until_done", busy_low, 0);
    @(negedge Clk);
    chk("done_one_cycle", Done, 0);
  endtask

  int           n, e0;
  logic [127:0] est, ek;

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));

    #2 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_data", Data_out, 0);
    chk("rst_key", Rk_cur, 0);
    chk("rst_ctrl", {Busy, Done, Err, Round_num, en_v}, 0);
    Rst_n = 1'b1;

    // Nominal FIPS-197 run, single-cycle blocks.
    do_start(1'b1, 100);
    chk("busy_after_start", {Busy, Err}, 2'b10);
    wait_done(300);

    // SB takes four extra cycles every round.
    lat_sb = 4;
    do_start(1'b1, 140);
    wait_done(400);
    lat_sb = 0;

    // MC never answers in round 3.
    hang_mc = 1'b1;
    do_start(1'b0, 0);
    n = 0;
    while (!(En_MC === 1'b1 && Round_num == 4'd3) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("mc_r3_reached", En_MC, 1);
    e0 = edge_cnt;
    n = 0;
    while (Err !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("err_edge", edge_cnt - e0, TO_CYC);
    chk("err_outputs", {Err, Busy, Done, en_v}, 8'b1000_0000);
    repeat (3) @(negedge Clk);
    chk("err_sticky", {Err, Busy}, 2'b10);
    hang_mc = 1'b0;
    do_start(1'b1, 100);
    chk("err_cleared", Err, 0);
    wait_done(300);

    // Abort coinciding with the round-5 SR capture.
    est = PT ^ KEY;
    ek  = KEY;
    for (int r = 1; r <= 4; r++) begin
      ek  = f_ke(ek, 4'(r));
      est = f_mc(f_sr(f_sb(est))) ^ ek;
    end
    ek  = f_ke(ek, 4'd5);
    est = f_sb(est);
    do_start(1'b0, 0);
    n = 0;
    while (!(En_SR === 1'b1 && Ry_SR === 1'b1 && Round_num == 4'd5) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("sr_r5_reached", {En_SR, Ry_SR}, 2'b11);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_ctrl", {Busy, Done, en_v}, 0);
    chk("abort_state_kept", Data_out, est);
    chk("abort_key_kept", Rk_cur, ek);
    repeat (3) @(negedge Clk);
    chk("abort_stays_idle", {Busy, Done, en_v}, 0);

    // Start pulsed mid-run with different operands must be ignored.
    do_start(1'b1, 100);
    repeat (30) @(negedge Clk);
    Data_in = ~PT;
    Key_in  = ~KEY;
    Start   = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = (edge_cnt - start_edge) / 2;
    chk("busy_after_ignored_start", Busy, 1);
    chk("round_unaffected", Round_num, (n == 0) ? 0 : 1 + (n - 1) / 5);
    wait_done(300);

    // Asynchronous reset pulse in round 7, between clock edges.
    do_start(1'b0, 0);
    n = 0;
    while (Round_num != 4'd7 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("r7_reached", Round_num, 7);
    #1 Rst_n = 1'b0;
    #1;
    chk("midrst_data", Data_out, 0);
    chk("midrst_key", Rk_cur, 0);
    chk("midrst_ctrl", {Busy, Done, Err, Round_num, en_v}, 0);
    #2 Rst_n = 1'b1;
    do_start(1'b1, 100);
    wait_done(300);

    repeat (3) @(negedge Clk);
    chk("queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
